// File: rtl/lfsr_bus_slave.sv
// ---------------------------------------------------------------------------
// lfsr_bus_slave
//   Memory-mapped pseudo-random byte source on the CPU register bus.
//   An 8-bit Galois LFSR fills a small output FIFO while enabled; the CPU
//   seeds, enables, pops and monitors it through four byte registers.
//
//   Register map (relative to ADDR_BASE):
//     +0 CTRL   RW  bit0 EN, bit1 CLR (write-1 flush, reads 0)
//     +1 SEED   RW  write loads lfsr (0 coerced to 1), read returns lfsr
//     +2 DATA   RO  read returns FIFO head and pops it (0 when empty)
//     +3 STATUS RO  {2'b0, underflow, empty, full, count[2:0]}, read clears underflow
//
// Ports
//   clk      in   1  clock, all state on posedge
//   reset    in   1  asynchronous, active-low reset
//   ce       in   1  chip enable; bus access only when high
//   rd       in   1  read strobe, qualified by ce
//   wr       in   1  write strobe, qualified by ce (wins over rd)
//   addr     in   8  register address
//   data_wr  in   8  write data
//   data_rd  out  8  registered read data, held between reads
//   irq      out  1  registered FIFO-full flag
// ---------------------------------------------------------------------------
module lfsr_bus_slave #(
  parameter logic [7:0] ADDR_BASE  = 8'h10,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] POLY       = 8'hB8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] addr,
  input  logic [7:0] data_wr,
  output logic [7:0] data_rd,
  output logic       irq
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  localparam logic [7:0] A_CTRL   = ADDR_BASE;
  localparam logic [7:0] A_SEED   = ADDR_BASE + 8'd1;
  localparam logic [7:0] A_DATA   = ADDR_BASE + 8'd2;
  localparam logic [7:0] A_STATUS = ADDR_BASE + 8'd3;

  logic [7:0]    lfsr;
  logic          en;
  logic          underflow;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [7:0]    mem [FIFO_DEPTH];

  logic       wr_acc, rd_acc;
  logic       ctrl_wr, seed_wr, data_acc, status_rd, clr;
  logic       full, empty, pop, push;
  logic [7:0] lfsr_nxt;
  logic [3:0] count_ext;
  logic [7:0] status_byte;
  logic [7:0] rd_mux;

  // Bus decode, FIFO handshake and read-data mux. A write always wins over
  // a simultaneous read, so a DATA pop and any register write (SEED, CLR)
  // can never coincide.
  always_comb begin
    wr_acc    = ce & wr;
    rd_acc    = ce & rd & ~wr;
    ctrl_wr   = wr_acc && (addr == A_CTRL);
    seed_wr   = wr_acc && (addr == A_SEED);
    data_acc  = rd_acc && (addr == A_DATA);
    status_rd = rd_acc && (addr == A_STATUS);
    clr       = ctrl_wr & data_wr[1];

    lfsr_nxt  = (lfsr >> 1) ^ (lfsr[0] ? POLY : 8'h00);

    full      = (count == FULL_COUNT);
    empty     = (count == '0);
    pop       = data_acc & ~empty;
    // A pop frees the slot this cycle, so a full FIFO can still accept the
    // new byte; a seed load or flush suppresses generation for the cycle.
    push      = en & (~full | pop) & ~seed_wr & ~clr;

    count_ext   = 4'(count);
    status_byte = {2'b00, underflow, empty, full, count_ext[2:0]};

    rd_mux = 8'h00;
    case (addr)
      A_CTRL:   rd_mux = {7'b0, en};
      A_SEED:   rd_mux = lfsr;
      A_DATA:   rd_mux = empty ? 8'h00 : mem[rd_ptr];
      A_STATUS: rd_mux = status_byte;
      default:  rd_mux = 8'h00;
    endcase
  end

  // Control, LFSR, FIFO bookkeeping and registered bus outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr      <= 8'h01;
      en        <= 1'b0;
      underflow <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      data_rd   <= 8'h00;
      irq       <= 1'b0;
    end else begin
      if (ctrl_wr)
        en <= data_wr[0];

      if (seed_wr)
        lfsr <= (data_wr == 8'h00) ? 8'h01 : data_wr;
      else if (push)
        lfsr <= lfsr_nxt;

      if (clr) begin
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        count     <= '0;
        underflow <= 1'b0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)
          count <= count + 1'b1;
        else if (pop && !push)
          count <= count - 1'b1;

        if (data_acc && empty)
          underflow <= 1'b1;
        else if (status_rd)
          underflow <= 1'b0;
      end

      if (rd_acc)
        data_rd <= rd_mux;

      irq <= full;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= lfsr_nxt;
  end

endmodule

// File: tb/tb_lfsr_bus_slave.sv
// ---------------------------------------------------------------------------
// tb_lfsr_bus_slave
//   Directed self-checking bench for lfsr_bus_slave. Inputs change on the
//   falling edge; outputs are sampled on the falling edge after the rising
//   edge that acted on them.
// ---------------------------------------------------------------------------
module tb_lfsr_bus_slave;

  localparam logic [7:0] A_CTRL   = 8'h10;
  localparam logic [7:0] A_SEED   = 8'h11;
  localparam logic [7:0] A_DATA   = 8'h12;
  localparam logic [7:0] A_STATUS = 8'h13;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ce = 1'b0;
  logic       rd = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] data_wr = 8'h00;
  logic [7:0] data_rd;
  logic       irq;

  int checks = 0;
  int failures = 0;

  lfsr_bus_slave #(
    .ADDR_BASE (8'h10),
    .FIFO_DEPTH(4),
    .POLY      (8'hB8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .ce     (ce),
    .rd     (rd),
    .wr     (wr),
    .addr   (addr),
    .data_wr(data_wr),
    .data_rd(data_rd),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  // Bus helpers: called at a falling edge, return at the next falling edge.
  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    ce = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; data_wr = d;
    @(negedge clk);
    ce = 1'b0; wr = 1'b0; data_wr = 8'h00;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    ce = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
    @(negedge clk);
    d = data_rd;
    ce = 1'b0; rd = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    checks++;
    if (data_rd !== 8'h00 || irq !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: data_rd=%h irq=%b, expected 00/0", data_rd, irq);
    end
    bus_read(A_STATUS, v);
    checks++;
    if (v !== 8'h10) begin
      failures++;
      $display("[TB] FAIL reset_status: got %h expected 10", v);
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_irq: got %b expected 0", irq);
    end
  endtask

  task automatic test_fill_and_drain();
    logic [7:0] v;
    logic [7:0] exp_seq [4];
    exp_seq = '{8'hB8, 8'h5C, 8'h2E, 8'h17};
    bus_write(A_SEED, 8'h01);
    bus_write(A_CTRL, 8'h01);
    repeat (6) @(negedge clk);
    bus_read(A_STATUS, v);
    checks++;
    if (v !== 8'h0C) begin
      failures++;
      $display("[TB] FAIL fill_status: got %h expected 0C", v);
    end
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("[TB] FAIL fill_irq: got %b expected 1", irq);
    end
    bus_write(A_CTRL, 8'h00);
    for (int i = 0; i < 4; i++) begin
      bus_read(A_DATA, v);
      checks++;
      if (v !== exp_seq[i]) begin
        failures++;
        $display("[TB] FAIL drain_data[%0d]: got %h expected %h", i, v, exp_seq[i]);
      end
    end
  endtask

  task automatic test_underflow();
    logic [7:0] v;
    bus_read(A_DATA, v);
    checks++;
    if (v !== 8'h00) begin
      failures++;
      $display("[TB] FAIL empty_read: got %h expected 00", v);
    end
    bus_read(A_STATUS, v);
    checks++;
    if (v !== 8'h30) begin
      failures++;
      $display("[TB] FAIL underflow_status: got %h expected 30", v);
    end
    bus_read(A_STATUS, v);
    checks++;
    if (v !== 8'h10) begin
      failures++;
      $display("[TB] FAIL underflow_cleared: got %h expected 10", v);
    end
  endtask

  task automatic test_seed_and_rdwr();
    logic [7:0] v;
    bus_write(A_SEED, 8'h00);
    bus_read(A_SEED, v);
    checks++;
    if (v !== 8'h01) begin
      failures++;
      $display("[TB] FAIL seed_zero_coerce: got %h expected 01", v);
    end
    // Read and write together: the write lands, the read is dropped.
    ce = 1'b1; rd = 1'b1; wr = 1'b1; addr = A_CTRL; data_wr = 8'h01;
    @(negedge clk);
    ce = 1'b0; rd = 1'b0; wr = 1'b0; data_wr = 8'h00;
    checks++;
    if (data_rd !== 8'h01) begin
      failures++;
      $display("[TB] FAIL rdwr_data_hold: got %h expected 01", data_rd);
    end
    bus_read(A_CTRL, v);
    checks++;
    if (v !== 8'h01) begin
      failures++;
      $display("[TB] FAIL rdwr_ctrl_written: got %h expected 01", v);
    end
    bus_write(A_CTRL, 8'h02);
    bus_read(A_CTRL, v);
    checks++;
    if (v !== 8'h00) begin
      failures++;
      $display("[TB] FAIL ctrl_clr_reads0: got %h expected 00", v);
    end
    bus_read(A_STATUS, v);
    checks++;
    if (v !== 8'h10) begin
      failures++;
      $display("[TB] FAIL clr_flush_status: got %h expected 10", v);
    end
  endtask

  task automatic test_unmapped();
    logic [7:0] v;
    bus_write(A_SEED, 8'h5A);
    bus_write(8'h14, 8'h33);
    bus_write(8'h0F, 8'h77);
    bus_read(A_SEED, v);
    checks++;
    if (v !== 8'h5A) begin
      failures++;
      $display("[TB] FAIL unmapped_write_ignored: got %h expected 5A", v);
    end
    bus_read(8'h14, v);
    checks++;
    if (v !== 8'h00) begin
      failures++;
      $display("[TB] FAIL unmapped_read: got %h expected 00", v);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    logic [7:0] exp_seq [10];
    exp_seq = '{8'hB3, 8'hE1, 8'hC8, 8'h64, 8'h32,
                8'h19, 8'hB4, 8'h5A, 8'h2D, 8'hAE};
    bus_write(A_SEED, 8'h17);
    bus_write(A_CTRL, 8'h01);
    repeat (6) @(negedge clk);
    ce = 1'b1; rd = 1'b1; wr = 1'b0; addr = A_DATA;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (data_rd !== exp_seq[i]) begin
        failures++;
        $display("[TB] FAIL stream_data[%0d]: got %h expected %h", i, data_rd, exp_seq[i]);
      end
      checks++;
      if (irq !== 1'b1) begin
        failures++;
        $display("[TB] FAIL stream_irq[%0d]: got %b expected 1", i, irq);
      end
    end
    ce = 1'b0; rd = 1'b0;
    bus_read(A_STATUS, v);
    checks++;
    if (v !== 8'h0C) begin
      failures++;
      $display("[TB] FAIL stream_count_full: got %h expected 0C", v);
    end
    bus_write(A_CTRL, 8'h02);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("[TB] FAIL clr_irq_lag: got %b expected 1", irq);
    end
    bus_read(A_STATUS, v);
    checks++;
    if (v !== 8'h10) begin
      failures++;
      $display("[TB] FAIL clr_status: got %h expected 10", v);
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("[TB] FAIL clr_irq_fall: got %b expected 0", irq);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0] v;
    bus_write(A_SEED, 8'h01);
    bus_write(A_CTRL, 8'h01);
    repeat (6) @(negedge clk);
    ce = 1'b1; rd = 1'b1; wr = 1'b0; addr = A_DATA;
    @(negedge clk);
    checks++;
    if (data_rd !== 8'hB8 || irq !== 1'b1) begin
      failures++;
      $display("[TB] FAIL burst_pre_reset: data_rd=%h irq=%b expected B8/1", data_rd, irq);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (data_rd !== 8'h00 || irq !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_reset: data_rd=%h irq=%b expected 00/0", data_rd, irq);
    end
    ce = 1'b0; rd = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus_read(A_STATUS, v);
    checks++;
    if (v !== 8'h10) begin
      failures++;
      $display("[TB] FAIL post_reset_status: got %h expected 10", v);
    end
    bus_read(A_SEED, v);
    checks++;
    if (v !== 8'h01) begin
      failures++;
      $display("[TB] FAIL post_reset_seed: got %h expected 01", v);
    end
    bus_read(A_CTRL, v);
    checks++;
    if (v !== 8'h00) begin
      failures++;
      $display("[TB] FAIL post_reset_ctrl: got %h expected 00", v);
    end
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_fill_and_drain();
    test_underflow();
    test_seed_and_rdwr();
    test_unmapped();
    test_back_to_back();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
